// File: rtl/ps2_host_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ps2_host_ctrl
// Description : PS/2 host-to-device command engine. Sends the keyboard reset
//               (0xFF, expects 0xFA then 0xAA) and LED update (0xED, 0xFA,
//               {5'b0,LEDS}, 0xFA) sequences. It owns the PS/2 lines while a
//               command is in flight and tells the key matrix to ignore the
//               received bytes.
// Ports       : CLK, nRESET            system clock, async active-low reset
//               PS2_CLK_IN/DATA_IN     raw PS/2 line levels (asynchronous)
//               PS2_CLK_OE/DATA_OE     1 = pull the PS/2 line low
//               RX_DATA/RX_VALID       bytes decoded by the receive block
//               REQ_RESET/REQ_LEDS     command request pulses, LEDS payload
//               RX_BLOCK, BUSY         command in progress indicators
//               DONE, ERROR            one-cycle completion / abort pulses
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_host_ctrl #(
    parameter int INHIBIT_CYCLES = 3200,
    parameter int TIMEOUT_CYCLES = 640000
) (
    input  logic       CLK,
    input  logic       nRESET,
    input  logic       PS2_CLK_IN,
    input  logic       PS2_DATA_IN,
    output logic       PS2_CLK_OE,
    output logic       PS2_DATA_OE,
    input  logic [7:0] RX_DATA,
    input  logic       RX_VALID,
    input  logic       REQ_RESET,
    input  logic       REQ_LEDS,
    input  logic [2:0] LEDS,
    output logic       RX_BLOCK,
    output logic       BUSY,
    output logic       DONE,
    output logic       ERROR
);

    localparam int c_MAX_CYCLES = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
    localparam int c_CNT_W      = $clog2(c_MAX_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_INH_LAST = c_CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_TMO_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0] c_CMD_RESET = 8'hFF;
    localparam logic [7:0] c_CMD_LEDS  = 8'hED;
    localparam logic [7:0] c_RSP_ACK   = 8'hFA;
    localparam logic [7:0] c_RSP_BAT   = 8'hAA;
    localparam logic [7:0] c_RSP_RESND = 8'hFE;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_INHIBIT   = 3'd1,
        S_RTS       = 3'd2,
        S_TX_BITS   = 3'd3,
        S_TX_ACK    = 3'd4,
        S_WAIT_RESP = 3'd5
    } state_t;

    state_t               r_state;
    logic                 r_clk_s1, r_clk_s2, r_clk_d;
    logic                 r_dat_s1, r_dat_s2;
    logic                 r_pend_rst, r_pend_led;
    logic [2:0]           r_leds;
    logic                 r_cmd_led;      // 0 = reset command, 1 = LED command
    logic [2:0]           r_cmd_leds;     // LED payload frozen at command start
    logic                 r_step;         // second byte/response of the command
    logic [1:0]           r_retry;
    logic [c_CNT_W-1:0]   r_cnt;          // shared inhibit / timeout counter
    logic [3:0]           r_bit_cnt;      // falling edges seen in TX_BITS
    logic                 r_clk_oe, r_data_oe, r_done, r_error;

    logic                 w_fall;
    logic                 w_tmo;
    logic [7:0]           w_cur_byte;
    logic [7:0]           w_expect;

    assign w_fall     = r_clk_d & ~r_clk_s2;
    assign w_tmo      = (r_cnt == c_TMO_LAST);
    assign w_cur_byte = !r_cmd_led ? c_CMD_RESET : (r_step ? {5'b0, r_cmd_leds} : c_CMD_LEDS);
    // The reset command has no second byte: its second response is the BAT code.
    assign w_expect   = (!r_cmd_led && r_step) ? c_RSP_BAT : c_RSP_ACK;

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            r_state    <= S_IDLE;
            r_clk_s1   <= 1'b1;
            r_clk_s2   <= 1'b1;
            r_clk_d    <= 1'b1;
            r_dat_s1   <= 1'b1;
            r_dat_s2   <= 1'b1;
            r_pend_rst <= 1'b0;
            r_pend_led <= 1'b0;
            r_leds     <= 3'b000;
            r_cmd_led  <= 1'b0;
            r_cmd_leds <= 3'b000;
            r_step     <= 1'b0;
            r_retry    <= 2'd0;
            r_cnt      <= '0;
            r_bit_cnt  <= 4'd0;
            r_clk_oe   <= 1'b0;
            r_data_oe  <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_clk_s1 <= PS2_CLK_IN;
            r_clk_s2 <= r_clk_s1;
            r_clk_d  <= r_clk_s2;
            r_dat_s1 <= PS2_DATA_IN;
            r_dat_s2 <= r_dat_s1;
            r_done   <= 1'b0;
            r_error  <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    r_clk_oe  <= 1'b0;
                    r_data_oe <= 1'b0;
                    if (r_pend_rst || r_pend_led) begin
                        if (r_pend_rst) begin
                            r_pend_rst <= 1'b0;
                            r_cmd_led  <= 1'b0;
                        end else begin
                            r_pend_led <= 1'b0;
                            r_cmd_led  <= 1'b1;
                            r_cmd_leds <= r_leds;
                        end
                        r_step   <= 1'b0;
                        r_retry  <= 2'd0;
                        r_cnt    <= '0;
                        r_clk_oe <= 1'b1;
                        r_state  <= S_INHIBIT;
                    end
                end

                S_INHIBIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_INH_LAST) begin
                        // Start bit: pull data low and let the device clock.
                        r_clk_oe  <= 1'b0;
                        r_data_oe <= 1'b1;
                        r_state   <= S_RTS;
                    end
                end

                S_RTS: begin
                    r_cnt     <= '0;
                    r_bit_cnt <= 4'd0;
                    r_state   <= S_TX_BITS;
                end

                S_TX_BITS: begin
                    if (w_tmo) begin
                        r_error   <= 1'b1;
                        r_clk_oe  <= 1'b0;
                        r_data_oe <= 1'b0;
                        r_state   <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        if (w_fall) begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                            if (r_bit_cnt < 4'd8) begin
                                r_data_oe <= ~w_cur_byte[r_bit_cnt[2:0]];
                            end else if (r_bit_cnt == 4'd8) begin
                                // Odd parity bit is ~^byte; the line is pulled low for a 0.
                                r_data_oe <= ^w_cur_byte;
                            end else begin
                                r_data_oe <= 1'b0;
                                r_cnt     <= '0;
                                r_state   <= S_TX_ACK;
                            end
                        end
                    end
                end

                S_TX_ACK: begin
                    if (w_fall && !r_dat_s2) begin
                        r_cnt   <= '0;
                        r_state <= S_WAIT_RESP;
                    end else if (w_fall || w_tmo) begin
                        r_error <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                S_WAIT_RESP: begin
                    if (RX_VALID) begin
                        if (RX_DATA == w_expect) begin
                            if (r_step) begin
                                r_done  <= 1'b1;
                                r_state <= S_IDLE;
                            end else begin
                                r_step  <= 1'b1;
                                r_retry <= 2'd0;
                                r_cnt   <= '0;
                                if (r_cmd_led) begin
                                    r_clk_oe <= 1'b1;
                                    r_state  <= S_INHIBIT;
                                end
                            end
                        end else if (RX_DATA == c_RSP_RESND && r_retry != 2'd3) begin
                            r_retry  <= r_retry + 2'd1;
                            r_cnt    <= '0;
                            r_clk_oe <= 1'b1;
                            r_state  <= S_INHIBIT;
                            // A resend during the BAT wait repeats the 0xFF byte.
                            if (!r_cmd_led) begin
                                r_step <= 1'b0;
                            end
                        end else begin
                            r_error <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end else if (w_tmo) begin
                        r_error <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                default: begin
                    r_clk_oe  <= 1'b0;
                    r_data_oe <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase

            // New requests win over the clear done when a command starts.
            if (REQ_RESET) begin
                r_pend_rst <= 1'b1;
            end
            if (REQ_LEDS) begin
                r_pend_led <= 1'b1;
                r_leds     <= LEDS;
            end
        end
    end

    assign PS2_CLK_OE  = r_clk_oe;
    assign PS2_DATA_OE = r_data_oe;
    assign BUSY        = (r_state != S_IDLE);
    assign RX_BLOCK    = (r_state != S_IDLE);
    assign DONE        = r_done;
    assign ERROR       = r_error;

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_ps2_host_ctrl
// Description : Directed bench for ps2_host_ctrl with an open-collector PS/2
//               device model and a queue of expected transmitted bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_host_ctrl;

    localparam int INH = 20;
    localparam int TMO = 2000;

    logic       CLK = 1'b0;
    logic       nRESET = 1'b0;
    logic       PS2_CLK_OE, PS2_DATA_OE;
    logic [7:0] RX_DATA = 8'h00;
    logic       RX_VALID = 1'b0;
    logic       REQ_RESET = 1'b0;
    logic       REQ_LEDS = 1'b0;
    logic [2:0] LEDS = 3'b000;
    logic       RX_BLOCK, BUSY, DONE, ERROR;

    logic       dev_clk = 1'b1;
    logic       dev_dat = 1'b1;
    logic       line_clk, line_dat;

    assign line_clk = dev_clk & ~PS2_CLK_OE;
    assign line_dat = dev_dat & ~PS2_DATA_OE;

    ps2_host_ctrl #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
        .CLK(CLK), .nRESET(nRESET),
        .PS2_CLK_IN(line_clk), .PS2_DATA_IN(line_dat),
        .PS2_CLK_OE(PS2_CLK_OE), .PS2_DATA_OE(PS2_DATA_OE),
        .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
        .REQ_RESET(REQ_RESET), .REQ_LEDS(REQ_LEDS), .LEDS(LEDS),
        .RX_BLOCK(RX_BLOCK), .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR)
    );

    always #5 CLK = ~CLK;

    int         checks = 0;
    int         errors = 0;
    int         done_cnt = 0;
    int         err_cnt = 0;
    int         snap_d = 0;
    int         snap_e = 0;
    int         cyc = 0;
    int         err_cyc = 0;
    bit         line_act = 1'b0;
    logic [7:0] exp_q[$];

    always @(posedge CLK) cyc++;

    always @(negedge CLK) begin
        if (DONE) done_cnt++;
        if (ERROR) begin
            err_cnt++;
            err_cyc = cyc;
        end
        if (PS2_CLK_OE || PS2_DATA_OE) line_act = 1'b1;
        assert (!(DONE && ERROR)) else begin
            errors++;
            $error("FAIL done_error_overlap observed=%0b%0b expected=not both", DONE, ERROR);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog observed=time limit expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        snap_d = done_cnt;
        snap_e = err_cnt;
    endtask

    task automatic pulse_req(input bit r, input bit l, input logic [2:0] leds);
        @(posedge CLK); #1;
        REQ_RESET = r;
        REQ_LEDS  = l;
        LEDS      = leds;
        @(posedge CLK); #1;
        REQ_RESET = 1'b0;
        REQ_LEDS  = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] d);
        repeat (3) @(posedge CLK);
        #1;
        RX_DATA  = d;
        RX_VALID = 1'b1;
        @(posedge CLK); #1;
        RX_VALID = 1'b0;
    endtask

    // Device side of one host-to-device frame: waits for request-to-send,
    // clocks 11 pulses, samples bits on rising edges, optionally acks.
    // stop_edge > 0 returns in the low phase of that falling edge.
    task automatic dev_receive(input bit ack, input int stop_edge, output bit aborted);
        bit         seen;
        bit         got;
        logic [7:0] b;
        logic [7:0] e;
        logic       par;
        logic       stp;
        aborted = 1'b0;
        seen = 1'b0;
        got = 1'b0;
        b = 8'h00;
        par = 1'b0;
        stp = 1'b0;
        for (int i = 0; i < INH + 200 && !got; i++) begin
            @(posedge CLK); #1;
            if (PS2_CLK_OE) seen = 1'b1;
            else if (seen && PS2_DATA_OE) got = 1'b1;
        end
        check("rts_seen", {31'd0, got}, 32'd1);
        if (!got) return;
        repeat (4) @(posedge CLK);
        #1;
        for (int k = 1; k <= 11; k++) begin
            if (k == 11 && ack) dev_dat = 1'b0;
            dev_clk = 1'b0;
            repeat (8) @(posedge CLK);
            #1;
            if (k == stop_edge) begin
                aborted = 1'b1;
                return;
            end
            dev_clk = 1'b1;
            if (k <= 8) b[k-1] = line_dat;
            else if (k == 9) par = line_dat;
            else if (k == 10) stp = line_dat;
            repeat (8) @(posedge CLK);
            #1;
            if (k == 11) dev_dat = 1'b1;
        end
        if (exp_q.size() == 0) begin
            check("unexpected_frame", {24'd0, b}, 32'hFFFF_FFFF);
        end else begin
            e = exp_q.pop_front();
            check("frame_byte", {24'd0, b}, {24'd0, e});
        end
        check("frame_parity_odd", {31'd0, par}, {31'd0, ~^b});
        check("frame_stop", {31'd0, stp}, 32'd1);
    endtask

    task automatic expect_end(input string tag, input int exp_d, input int exp_e, input int max);
        for (int i = 0; i < max; i++) begin
            if ((done_cnt - snap_d) + (err_cnt - snap_e) > 0) break;
            @(posedge CLK); #1;
        end
        repeat (5) @(posedge CLK);
        #1;
        check({tag, "_done"}, done_cnt - snap_d, exp_d);
        check({tag, "_error"}, err_cnt - snap_e, exp_e);
    endtask

    initial begin
        bit ab;
        int t0;

        repeat (3) @(posedge CLK);
        #1;
        check("reset_outputs", {26'd0, PS2_CLK_OE, PS2_DATA_OE, RX_BLOCK, BUSY, DONE, ERROR}, 32'd0);
        nRESET = 1'b1;
        repeat (3) @(posedge CLK);
        #1;

        // LED update, LEDS = caps only
        snap();
        exp_q.push_back(8'hED);
        exp_q.push_back(8'h04);
        pulse_req(1'b0, 1'b1, 3'b100);
        dev_receive(1'b1, 0, ab);
        check("led_busy_block", {30'd0, BUSY, RX_BLOCK}, 32'd3);
        send_rx(8'hFA);
        dev_receive(1'b1, 0, ab);
        send_rx(8'hFA);
        expect_end("led", 1, 0, 50);
        check("led_busy_fall", {31'd0, BUSY}, 32'd0);

        // Keyboard reset with BAT
        snap();
        exp_q.push_back(8'hFF);
        pulse_req(1'b1, 1'b0, 3'b000);
        dev_receive(1'b1, 0, ab);
        send_rx(8'hFA);
        repeat (20) @(posedge CLK);
        #1;
        check("bat_wait_no_done", done_cnt - snap_d, 32'd0);
        check("bat_wait_busy", {31'd0, BUSY}, 32'd1);
        send_rx(8'hAA);
        expect_end("rst", 1, 0, 50);

        // Simultaneous requests: reset first, LED update follows on its own
        snap();
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'hED);
        exp_q.push_back(8'h03);
        pulse_req(1'b1, 1'b1, 3'b011);
        dev_receive(1'b1, 0, ab);
        send_rx(8'hFA);
        send_rx(8'hAA);
        expect_end("simul_rst", 1, 0, 50);
        check("simul_led_autostart", {31'd0, BUSY}, 32'd1);
        snap();
        dev_receive(1'b1, 0, ab);
        send_rx(8'hFA);
        dev_receive(1'b1, 0, ab);
        send_rx(8'hFA);
        expect_end("simul_led", 1, 0, 50);
        check("simul_queue_empty", exp_q.size(), 32'd0);

        // No ack at edge 11
        snap();
        exp_q.push_back(8'hED);
        pulse_req(1'b0, 1'b1, 3'b001);
        dev_receive(1'b0, 0, ab);
        expect_end("noack", 0, 1, 100);
        check("noack_released", {29'd0, PS2_CLK_OE, PS2_DATA_OE, BUSY}, 32'd0);

        // Four resend requests
        snap();
        repeat (4) exp_q.push_back(8'hED);
        pulse_req(1'b0, 1'b1, 3'b010);
        for (int i = 0; i < 4; i++) begin
            dev_receive(1'b1, 0, ab);
            send_rx(8'hFE);
        end
        expect_end("resend", 0, 1, 50);
        check("resend_count", exp_q.size(), 32'd0);

        // Silent device
        snap();
        exp_q.push_back(8'hED);
        pulse_req(1'b0, 1'b1, 3'b000);
        dev_receive(1'b1, 0, ab);
        t0 = cyc;
        expect_end("timeout", 0, 1, TMO + 100);
        check("timeout_span", {31'd0, ((err_cyc - t0) >= TMO - 40) && ((err_cyc - t0) <= TMO + 5)}, 32'd1);

        // Reset at falling edge 5 of the data bits
        snap();
        exp_q.push_back(8'hED);
        pulse_req(1'b0, 1'b1, 3'b000);
        dev_receive(1'b1, 5, ab);
        check("mid_reached_edge5", {31'd0, ab}, 32'd1);
        check("mid_data_driven", {31'd0, PS2_DATA_OE}, 32'd1);
        nRESET = 1'b0;
        #1;
        check("mid_lines_released", {28'd0, PS2_CLK_OE, PS2_DATA_OE, BUSY, RX_BLOCK}, 32'd0);
        dev_clk = 1'b1;
        exp_q.delete();
        repeat (3) @(posedge CLK);
        #1;
        nRESET = 1'b1;
        line_act = 1'b0;
        repeat (300) @(posedge CLK);
        #1;
        check("mid_no_traffic", {30'd0, line_act, BUSY}, 32'd0);

        // Recovery with a fresh request
        snap();
        exp_q.push_back(8'hED);
        exp_q.push_back(8'h07);
        pulse_req(1'b0, 1'b1, 3'b111);
        dev_receive(1'b1, 0, ab);
        send_rx(8'hFA);
        dev_receive(1'b1, 0, ab);
        send_rx(8'hFA);
        expect_end("recover", 1, 0, 50);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
